rr_arbiter_4: RTL and testbench
===============================

// Module: rr_arbiter_4
// PURPOSE
//  Four-requester round-robin arbiter for one shared resource. The resource is,
//  for example, a shared result bus driven through the 4-input OR stage.
//  Grants exactly one requester at a time and holds the grant until that requester releases.
//  Ownership rotates fairly, so a continuously requesting client cannot starve the others.
//  Sits between the requesting units and the shared resource's select/enable logic.
// PARAMETERS
//  MAX_HOLD  8  max consecutive grant cycles per owner; used only with ARB_TIMEOUT_EN; legal 1..255
//  CNT_W     8  width of hold counter; must satisfy 2**CNT_W > MAX_HOLD
// PORTS
//  clk          in   1  rising-edge clock; sole clock
//  rst          in   1  synchronous reset, active-high
//  req          in   4  request vector; bit i = requester i wants the resource
//  grant        out  4  one-hot grant, registered; 4'b0000 when no owner
//  grant_valid  out  1  registered; 1 when grant != 0
//  grant_id     out  2  registered; index of owner; holds last owner when grant_valid=0
//  any_req      out  1  combinational OR of req[3:0]
//  timeout      out  1  registered one-cycle pulse on forced revoke; tied 0 without ARB_TIMEOUT_EN
// BEHAVIOUR
//  Reset (rst=1 at a clk edge; wins over everything):
//   grant=0, grant_valid=0, grant_id=0, timeout=0, ptr=0, hold count=0, state=IDLE.
//   Applies mid-grant: the grant drops at the same edge, with no release handshake.
//  State IDLE:
//   - req==0: stay in IDLE.
//   - req!=0: winner = first i with req[i]=1, searching ptr, ptr+1, ... mod 4.
//   - Next edge: grant=1<<winner, grant_valid=1, grant_id=winner, count=1, state=GRANT.
//   - Latency: req sampled high at edge k gives grant visible after edge k.
//  State GRANT, owner = grant_id:
//   - req[owner]=1: hold the grant; count increments, saturating at MAX_HOLD.
//     No preemption by other requesters.
//   - req[owner]=0: next edge grant=0, grant_valid=0, ptr=owner+1 (mod 4, 3 wraps to 0),
//     state=IDLE, count=0.
//   - Releasing forces a mandatory one-cycle bubble before the next grant.
//     Minimum turnaround: release to the next grant is 2 edges.
//  ptr is updated only on release, on revoke or by reset. It is never updated while in IDLE.
//  Requests from non-owners may rise or fall freely. They are sampled only in IDLE.
//  A requester that drops req in the same cycle it is granted still receives a one-cycle grant.
//  The grant is then released on the following edge.
//  grant is always one-hot or zero. grant_valid == |grant at all times.
// CONFIGURATION
//  Macro ARB_TIMEOUT_EN:
//   Defined:
//    - In GRANT, when count==MAX_HOLD and req[owner] is still 1, the next edge revokes the grant.
//    - Revoke sets grant=0, grant_valid=0, timeout=1 for one cycle, ptr=owner+1, state=IDLE.
//    - The revoked owner re-competes normally when ptr comes back to it.
//   Undefined:
//    - No counter logic is built; the owner holds the grant indefinitely.
//    - timeout is constant 0. MAX_HOLD and CNT_W are ignored.
// TESTING
//  1. rst=1 for 2 cycles with req=4'b1111 -> grant=0, grant_valid=0, grant_id=0 throughout.
//     First edge after rst=0 -> grant=4'b0001.
//  2. req=4'b1111; each owner drops its bit 3 cycles after being granted, then re-raises it
//     -> grant sequence 0001,0000,0010,0000,0100,0000,1000,0000,0001 (ptr wraps 3 -> 0).
//  3. From reset (ptr=0), req=4'b0100 only -> grant=0100 and grant_id=2 one edge later.
//     After release, req=4'b0011 -> grant=0001 (ptr=3 search order 3,0,1,2).
//  4. Owner 1 holds req[1]=1 for 20 cycles while req[0], req[3] pulse
//     -> grant stays 0010 all 20 cycles; no preemption (macro undefined).
//  5. ARB_TIMEOUT_EN, MAX_HOLD=8: req=4'b0011 held -> grant=0001 for 8 cycles, then timeout=1 and
//     grant=0 for 1 cycle, then grant=0010 for 8 cycles, then grant returns to 0001.
//  6. rst=1 for one edge while grant=0010 with req=4'b1111 -> grant=0 and ptr=0 after that edge.
//     Next edge -> grant=0001. any_req tracks |req combinationally in every case.

Source files
------------

// File: rtl/rr_arbiter_4.sv
// Four-requester round-robin arbiter with grant held until the owner releases.
// Optional hold-time limit with forced revoke is built when ARB_TIMEOUT_EN is defined.
module rr_arbiter_4 #(
    parameter int unsigned MAX_HOLD = 8,
    parameter int unsigned CNT_W    = 8
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [3:0] req,
    output logic [3:0] grant,
    output logic       grant_valid,
    output logic [1:0] grant_id,
    output logic       any_req,
    output logic       timeout
);

    typedef enum logic [0:0] {
        ST_IDLE  = 1'b0,
        ST_GRANT = 1'b1
    } state_t;

    if ((MAX_HOLD < 1) || (MAX_HOLD > 255) || ((2 ** CNT_W) <= MAX_HOLD)) begin : g_param_bad
        $error("rr_arbiter_4: illegal MAX_HOLD/CNT_W combination");
    end

    state_t     state_q, state_d;
    logic [3:0] grant_q, grant_d;
    logic       grant_valid_q, grant_valid_d;
    logic [1:0] grant_id_q, grant_id_d;
    logic [1:0] ptr_q, ptr_d;
    logic       timeout_q, timeout_d;
    logic [1:0] win_s;
`ifdef ARB_TIMEOUT_EN
    logic [CNT_W-1:0] cnt_q, cnt_d;
`endif

    // First requester at or after ptr, wrapping modulo 4.
    function automatic logic [1:0] pick_winner(input logic [3:0] r, input logic [1:0] p);
        logic [1:0] idx;
        logic [1:0] win;
        logic       found;
        win   = p;
        found = 1'b0;
        for (int k = 0; k < 4; k++) begin
            idx = p + 2'(k);
            if (!found && r[idx]) begin
                win   = idx;
                found = 1'b1;
            end
        end
        return win;
    endfunction

    assign any_req     = |req;
    assign win_s       = pick_winner(req, ptr_q);
    assign grant       = grant_q;
    assign grant_valid = grant_valid_q;
    assign grant_id    = grant_id_q;
    assign timeout     = timeout_q;

    // Next-state logic: arbitration in IDLE, hold/release (and optional revoke) in GRANT.
    always_comb begin
        state_d       = state_q;
        grant_d       = grant_q;
        grant_valid_d = grant_valid_q;
        grant_id_d    = grant_id_q;
        ptr_d         = ptr_q;
        timeout_d     = 1'b0;
`ifdef ARB_TIMEOUT_EN
        cnt_d         = cnt_q;
`endif
        case (state_q)
            ST_IDLE: begin
                if (any_req) begin
                    state_d       = ST_GRANT;
                    grant_d       = 4'b0001 << win_s;
                    grant_valid_d = 1'b1;
                    grant_id_d    = win_s;
`ifdef ARB_TIMEOUT_EN
                    cnt_d         = CNT_W'(1);
`endif
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_GRANT: begin
                if (!req[grant_id_q]) begin
                    state_d       = ST_IDLE;
                    grant_d       = 4'b0000;
                    grant_valid_d = 1'b0;
                    ptr_d         = grant_id_q + 2'd1;
`ifdef ARB_TIMEOUT_EN
                    cnt_d         = {CNT_W{1'b0}};
`endif
                end else begin
`ifdef ARB_TIMEOUT_EN
                    // Owner still requesting after its full quota: revoke and pass the pointer on.
                    if (cnt_q == CNT_W'(MAX_HOLD)) begin
                        state_d       = ST_IDLE;
                        grant_d       = 4'b0000;
                        grant_valid_d = 1'b0;
                        ptr_d         = grant_id_q + 2'd1;
                        timeout_d     = 1'b1;
                        cnt_d         = {CNT_W{1'b0}};
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
`else
                    state_d = ST_GRANT;
`endif
                end
            end
            default: begin
                state_d       = ST_IDLE;
                grant_d       = 4'b0000;
                grant_valid_d = 1'b0;
`ifdef ARB_TIMEOUT_EN
                cnt_d         = {CNT_W{1'b0}};
`endif
            end
        endcase
    end

    // State and output registers; reset drops any grant immediately.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= ST_IDLE;
            grant_q       <= 4'b0000;
            grant_valid_q <= 1'b0;
            grant_id_q    <= 2'd0;
            ptr_q         <= 2'd0;
            timeout_q     <= 1'b0;
`ifdef ARB_TIMEOUT_EN
            cnt_q         <= {CNT_W{1'b0}};
`endif
        end else begin
            state_q       <= state_d;
            grant_q       <= grant_d;
            grant_valid_q <= grant_valid_d;
            grant_id_q    <= grant_id_d;
            ptr_q         <= ptr_d;
            timeout_q     <= timeout_d;
`ifdef ARB_TIMEOUT_EN
            cnt_q         <= cnt_d;
`endif
        end
    end

endmodule

// File: tb/tb_rr_arbiter_4.sv
// Directed self-checking bench for rr_arbiter_4.
module tb_rr_arbiter_4;

    logic       clk;
    logic       rst;
    logic [3:0] req;
    logic [3:0] grant;
    logic       grant_valid;
    logic [1:0] grant_id;
    logic       any_req;
    logic       timeout;

    int total;
    int bad;

    rr_arbiter_4 #(.MAX_HOLD(8), .CNT_W(8)) dut (
        .clk         (clk),
        .rst         (rst),
        .req         (req),
        .grant       (grant),
        .grant_valid (grant_valid),
        .grant_id    (grant_id),
        .any_req     (any_req),
        .timeout     (timeout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        req = 4'b0000;
        tick();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        req = 4'b1111;
        for (int c = 0; c < 2; c++) begin
            tick();
            total++;
            if (grant !== 4'b0000 || grant_valid !== 1'b0 || grant_id !== 2'd0) begin
                bad++;
                $display("FAIL reset_hold: grant=%b valid=%b id=%0d, want 0000/0/0", grant, grant_valid, grant_id);
            end
        end
        total++;
        if (any_req !== 1'b1) begin
            bad++;
            $display("FAIL reset_any_req: got %b want 1", any_req);
        end
        rst = 1'b0;
        tick();
        total++;
        if (grant !== 4'b0001 || grant_valid !== 1'b1 || grant_id !== 2'd0) begin
            bad++;
            $display("FAIL reset_first_grant: grant=%b valid=%b id=%0d, want 0001/1/0", grant, grant_valid, grant_id);
        end
    endtask

    // Continues from test_reset: owner 0 already granted with req=1111.
    task automatic test_rotation();
        logic [3:0] exp_g;
        logic [3:0] nxt_g;
        for (int k = 0; k < 4; k++) begin
            exp_g = 4'b0001 << k;
            for (int c = 0; c < 2; c++) begin
                tick();
                total++;
                if (grant !== exp_g) begin
                    bad++;
                    $display("FAIL rot_hold%0d: got %b want %b", k, grant, exp_g);
                end
            end
            req = 4'b1111 & ~exp_g;
            tick();
            total++;
            if (grant !== 4'b0000 || grant_valid !== 1'b0 || grant_id !== 2'(k)) begin
                bad++;
                $display("FAIL rot_bubble%0d: grant=%b valid=%b id=%0d, want 0000/0/%0d", k, grant, grant_valid, grant_id, k);
            end
            req = 4'b1111;
            tick();
            nxt_g = 4'b0001 << ((k + 1) % 4);
            total++;
            if (grant !== nxt_g || grant_id !== 2'((k + 1) % 4)) begin
                bad++;
                $display("FAIL rot_next%0d: grant=%b id=%0d, want %b/%0d", k, grant, grant_id, nxt_g, (k + 1) % 4);
            end
        end
    endtask

    task automatic test_ptr_search();
        do_reset();
        req = 4'b0100;
        tick();
        total++;
        if (grant !== 4'b0100 || grant_id !== 2'd2) begin
            bad++;
            $display("FAIL single_req: grant=%b id=%0d, want 0100/2", grant, grant_id);
        end
        req = 4'b0000;
        #1;
        total++;
        if (any_req !== 1'b0) begin
            bad++;
            $display("FAIL any_req_low: got %b want 0", any_req);
        end
        tick();
        total++;
        if (grant !== 4'b0000 || grant_valid !== 1'b0) begin
            bad++;
            $display("FAIL single_release: grant=%b valid=%b, want 0000/0", grant, grant_valid);
        end
        req = 4'b0011;
        tick();
        total++;
        if (grant !== 4'b0001 || grant_id !== 2'd0) begin
            bad++;
            $display("FAIL ptr3_search: grant=%b id=%0d, want 0001/0", grant, grant_id);
        end
        req = 4'b0000;
        tick();
    endtask

    // A requester dropping req as it is granted still gets exactly one cycle.
    task automatic test_short_grant();
        do_reset();
        req = 4'b1000;
        tick();
        req = 4'b0000;
        total++;
        if (grant !== 4'b1000 || grant_valid !== 1'b1) begin
            bad++;
            $display("FAIL short_grant: grant=%b valid=%b, want 1000/1", grant, grant_valid);
        end
        tick();
        total++;
        if (grant !== 4'b0000 || grant_id !== 2'd3) begin
            bad++;
            $display("FAIL short_release: grant=%b id=%0d, want 0000/3", grant, grant_id);
        end
    endtask

`ifndef ARB_TIMEOUT_EN
    task automatic test_no_preempt();
        do_reset();
        req = 4'b0010;
        tick();
        for (int c = 0; c < 20; c++) begin
            total++;
            if (grant !== 4'b0010 || timeout !== 1'b0) begin
                bad++;
                $display("FAIL no_preempt%0d: grant=%b timeout=%b, want 0010/0", c, grant, timeout);
            end
            req = (c % 2 == 0) ? 4'b1011 : 4'b0010;
            tick();
        end
        req = 4'b0000;
        tick();
    endtask
`else
    task automatic test_timeout();
        do_reset();
        req = 4'b0011;
        for (int ph = 0; ph < 2; ph++) begin
            for (int c = 0; c < 8; c++) begin
                tick();
                total++;
                if (grant !== (4'b0001 << ph) || timeout !== 1'b0) begin
                    bad++;
                    $display("FAIL to_hold%0d_%0d: grant=%b timeout=%b, want %b/0", ph, c, grant, timeout, 4'b0001 << ph);
                end
            end
            tick();
            total++;
            if (grant !== 4'b0000 || timeout !== 1'b1 || grant_valid !== 1'b0) begin
                bad++;
                $display("FAIL to_revoke%0d: grant=%b timeout=%b valid=%b, want 0000/1/0", ph, grant, timeout, grant_valid);
            end
        end
        tick();
        total++;
        if (grant !== 4'b0001 || timeout !== 1'b0) begin
            bad++;
            $display("FAIL to_return: grant=%b timeout=%b, want 0001/0", grant, timeout);
        end
        req = 4'b0000;
        tick();
    endtask
`endif

    task automatic test_mid_grant_reset();
        do_reset();
        req = 4'b0001;
        tick();
        req = 4'b0000;
        tick();
        req = 4'b0010;
        tick();
        total++;
        if (grant !== 4'b0010) begin
            bad++;
            $display("FAIL pre_reset_grant: got %b want 0010", grant);
        end
        req = 4'b1111;
        rst = 1'b1;
        tick();
        total++;
        if (grant !== 4'b0000 || grant_valid !== 1'b0 || grant_id !== 2'd0) begin
            bad++;
            $display("FAIL mid_reset: grant=%b valid=%b id=%0d, want 0000/0/0", grant, grant_valid, grant_id);
        end
        rst = 1'b0;
        tick();
        total++;
        if (grant !== 4'b0001) begin
            bad++;
            $display("FAIL post_reset_ptr: got %b want 0001", grant);
        end
    endtask

    initial begin
        total = 0;
        bad   = 0;
        rst   = 1'b1;
        req   = 4'b0000;
        #2;
        test_reset();
        test_rotation();
        test_ptr_search();
        test_short_grant();
`ifndef ARB_TIMEOUT_EN
        test_no_preempt();
`else
        test_timeout();
`endif
        test_mid_grant_reset();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
